// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: feeds the configuration-flop chain.
// Takes words over a valid/ready stream, shifts them LSB first onto ccff_head
// with a registered ccff_shift_en strobe, and flags done after CHAIN_LEN bits.
// Optional macro CCFF_TAIL_CHECK_EN: shifts a SENTINEL ahead of the data and
// checks it coming out of ccff_tail, reporting the result on chain_ok.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN  = 22,
  parameter int WORD_W     = 8,
  parameter int SENTINEL_W = 4,
  parameter logic [SENTINEL_W-1:0] SENTINEL = 4'b1011
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              chain_ok
);

`ifdef CCFF_TAIL_CHECK_EN
  localparam int PRE_LEN = SENTINEL_W;
`else
  localparam int PRE_LEN = 0;
`endif
  localparam int TOTAL     = CHAIN_LEN + PRE_LEN;
  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int TAIL_BITS = (CHAIN_LEN % WORD_W == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int CNT_W     = $clog2(TOTAL + 1);
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0]  TOTAL_C      = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  LAST_SHIFT_C = CNT_W'(TOTAL - 1);
  localparam logic [WCNT_W-1:0] NWORDS_C     = WCNT_W'(NUM_WORDS);
  localparam logic [WCNT_W-1:0] NWORDS_M1_C  = WCNT_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0]  FULL_LAST_C  = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0]  TAIL_LAST_C  = IDX_W'(TAIL_BITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_LOAD, ST_DONE} state_e;

`ifdef CCFF_TAIL_CHECK_EN
  localparam state_e FIRST_ST = ST_PRE;
  localparam logic [CNT_W-1:0] PRE_LAST_C = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] CHAIN_C    = CNT_W'(CHAIN_LEN);
  logic [SENTINEL_W-1:0] sent_q, sent_d;   // sentinel bits still to issue
  logic [SENTINEL_W-1:0] chk_q, chk_d;     // sentinel bits still to compare
  logic                  ok_acc_q, ok_acc_d;
  logic                  chain_ok_q, chain_ok_d;
  logic                  tail_match;
`else
  localparam state_e FIRST_ST = ST_LOAD;
  logic unused_tail;
  assign unused_tail = ^{ccff_tail, SENTINEL, 32'(SENTINEL_W)};
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;   // bits placed on ccff_head
  logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;   // shifts the chain has taken
  logic [WCNT_W-1:0]   words_q, words_d;           // words accepted this load
  logic [WORD_W-1:0]   buf_q, buf_d;               // shifted right as bits leave
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic                buf_valid_q, buf_valid_d;
  logic                head_q, head_d;
  logic                shift_en_q, shift_en_d;

  logic busy_w, issuing_data, buf_last, take_buf, take_new, ready_w, accept;
  logic [IDX_W-1:0] new_last_idx;

  // State and datapath registers.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      // NOTE: the word buffer data is reset too, so no X can ever reach ccff_head.
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      shift_cnt_q <= '0;
      words_q     <= '0;
      buf_q       <= '0;
      bit_idx_q   <= '0;
      buf_valid_q <= 1'b0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
      sent_q      <= '0;
      chk_q       <= '0;
      ok_acc_q    <= 1'b0;
      chain_ok_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      words_q     <= words_d;
      buf_q       <= buf_d;
      bit_idx_q   <= bit_idx_d;
      buf_valid_q <= buf_valid_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
`ifdef CCFF_TAIL_CHECK_EN
      sent_q      <= sent_d;
      chk_q       <= chk_d;
      ok_acc_q    <= ok_acc_d;
      chain_ok_q  <= chain_ok_d;
`endif
    end
  end

  // Next-state: pick the bit to present next cycle and track the buffer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    shift_cnt_d = shift_cnt_q;
    words_d     = words_q;
    buf_d       = buf_q;
    bit_idx_d   = bit_idx_q;
    buf_valid_d = buf_valid_q;
    head_d      = head_q;
    shift_en_d  = 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
    sent_d      = sent_q;
    chk_d       = chk_q;
    ok_acc_d    = ok_acc_q;
    chain_ok_d  = chain_ok_q;
    tail_match  = (ccff_tail == chk_q[0]);
`endif

    busy_w       = (state_q == ST_PRE) || (state_q == ST_LOAD);
    issuing_data = (state_q == ST_LOAD) && (issue_cnt_q != TOTAL_C);
    // The buffered word is the latest accepted one, so words_q tells if it is final.
    buf_last     = bit_idx_q == ((words_q == NWORDS_C) ? TAIL_LAST_C : FULL_LAST_C);
    take_buf     = issuing_data && buf_valid_q;
    ready_w      = busy_w && (words_q != NWORDS_C) && (!buf_valid_q || (take_buf && buf_last));
    accept       = ready_w && s_valid;
    take_new     = issuing_data && !buf_valid_q && accept;
    new_last_idx = (words_q == NWORDS_M1_C) ? TAIL_LAST_C : FULL_LAST_C;

    if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
      state_d     = FIRST_ST;
      issue_cnt_d = '0;
      shift_cnt_d = '0;
      words_d     = '0;
      buf_valid_d = 1'b0;
      bit_idx_d   = '0;
`ifdef CCFF_TAIL_CHECK_EN
      sent_d      = SENTINEL;
      chk_d       = SENTINEL;
      ok_acc_d    = 1'b1;
      chain_ok_d  = 1'b0;
`endif
    end else begin
      // A presented bit is shifted on this edge; the last one ends the load.
      if (shift_en_q) begin
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_q == LAST_SHIFT_C) state_d = ST_DONE;
      end
`ifdef CCFF_TAIL_CHECK_EN
      // Once the chain is full of sentinel, ccff_tail must replay it in order.
      if (shift_en_q && shift_cnt_q >= CHAIN_C) begin
        chk_d    = chk_q >> 1;
        ok_acc_d = ok_acc_q & tail_match;
        if (shift_cnt_q == LAST_SHIFT_C) chain_ok_d = ok_acc_q & tail_match;
      end
      if (state_q == ST_PRE) begin
        head_d      = sent_q[0];
        shift_en_d  = 1'b1;
        sent_d      = sent_q >> 1;
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == PRE_LAST_C) state_d = ST_LOAD;
      end
`endif
      if (take_buf) begin
        head_d      = buf_q[0];
        shift_en_d  = 1'b1;
        buf_d       = buf_q >> 1;
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (buf_last) buf_valid_d = 1'b0;
        else          bit_idx_d   = bit_idx_q + 1'b1;
      end
      if (accept) begin
        words_d = words_q + 1'b1;
        if (take_new) begin
          head_d      = s_data[0];
          shift_en_d  = 1'b1;
          buf_d       = s_data >> 1;
          bit_idx_d   = IDX_W'(1);
          buf_valid_d = (new_last_idx != '0);
          issue_cnt_d = issue_cnt_q + 1'b1;
        end else begin
          buf_d       = s_data;
          bit_idx_d   = '0;
          buf_valid_d = 1'b1;
        end
      end
    end
  end

  assign s_ready       = ready_w;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_w;
  assign done          = (state_q == ST_DONE);
`ifdef CCFF_TAIL_CHECK_EN
  assign chain_ok      = chain_ok_q;
`else
  assign chain_ok      = 1'b1;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: a 22-flop chain model on the main
// instance plus a CHAIN_LEN=16 instance for the word-count limit.
module tb_ccff_bitstream_loader;

`ifdef CCFF_TAIL_CHECK_EN
  localparam int PRE_LEN = 4;
  localparam logic [31:0] EXP_SEQ   = 32'h03F3_CA5B;  // {22'h3F3CA5, 4'b1011}
  localparam logic [31:0] EXP_SEQ16 = 32'h0002_211B;  // {16'h2211, 4'b1011}
  localparam logic        EXP_OK_STUCK = 1'b0;
  localparam logic        EXP_OK_RST   = 1'b0;
`else
  localparam int PRE_LEN = 0;
  localparam logic [31:0] EXP_SEQ   = 32'h003F_3CA5;
  localparam logic [31:0] EXP_SEQ16 = 32'h0000_2211;
  localparam logic        EXP_OK_STUCK = 1'b1;
  localparam logic        EXP_OK_RST   = 1'b1;
`endif
  localparam int TOTAL = 22 + PRE_LEN;
  localparam int GAP   = 8 + 2 + PRE_LEN;       // idle until 3 stall cycles occur
  localparam logic [21:0] EXP_CHAIN = 22'h294F3F; // first bit shifted sits at the tail

  logic       prog_clk = 1'b0, prog_reset_n = 1'b0;
  logic       start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, chain_ok;
  logic       start16 = 1'b0, s_valid16 = 1'b0;
  logic [7:0] s_data16 = '0;
  logic       s_ready16, head16, shen16, tail16, busy16, done16, ok16;

  logic [21:0] chain = '0, stuck = '0;
  logic [15:0] chain16 = '0;
  logic [7:0]  words [0:2] = '{8'hA5, 8'h3C, 8'hFF};
  logic [7:0]  words16 [0:2] = '{8'h11, 8'h22, 8'h33};

  int n_checks = 0, n_pass = 0;
  logic [31:0] seq;
  int nsh, first_sh, last_sh, lc;
  logic first_done;

  ccff_bitstream_loader #(.CHAIN_LEN(22), .WORD_W(8)) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .chain_ok(chain_ok));

  ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start16),
    .s_data(s_data16), .s_valid(s_valid16), .s_ready(s_ready16),
    .ccff_head(head16), .ccff_shift_en(shen16), .ccff_tail(tail16),
    .busy(busy16), .done(done16), .chain_ok(ok16));

  always #5 prog_clk = ~prog_clk;

  // Chain models; 'stuck' forces chosen flops to 0.
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[20:0], ccff_head} & ~stuck;
  always @(posedge prog_clk) if (shen16) chain16 <= {chain16[14:0], head16};
  assign ccff_tail = chain[21];
  assign tail16    = chain16[15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One load of words[] on the main instance. gap: s_valid low for that many
  // cycles after word 1; start_mid: iteration to re-pulse start; reset_at:
  // assert reset once that many bits were presented (and head is 1).
  task automatic run_load(input int gap, input int start_mid, input int reset_at,
                          output int load_cycles);
    int idx = 0, gap_left = 0;
    bit finished = 0;
    seq = '0; nsh = 0; first_sh = -1; last_sh = -1; load_cycles = -1; first_done = 1'b1;
    @(negedge prog_clk);
    start = 1'b1; s_valid = 1'b0;
    for (int k = 1; k <= 200 && !finished; k++) begin
      @(negedge prog_clk);
      start = (k == start_mid);
      if (k == 1) first_done = done;
      if (ccff_shift_en) begin
        if (nsh < 32) seq[nsh] = ccff_head;
        nsh++;
        if (first_sh < 0) first_sh = k;
        last_sh = k;
      end
      if (done) begin
        load_cycles = k - 1; s_valid = 1'b0; finished = 1;
      end else if (reset_at > 0 && nsh >= reset_at && ccff_head) begin
        prog_reset_n = 1'b0; s_valid = 1'b0; start = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", s_ready, 0);
        check("rst_head", ccff_head, 0);
        check("rst_shift_en", ccff_shift_en, 0);
        check("rst_chain_ok", chain_ok, EXP_OK_RST);
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        finished = 1;
      end else begin
        if (gap_left > 0) begin
          s_valid = 1'b0; gap_left--;
        end else if (idx < 3) begin
          s_valid = 1'b1; s_data = words[idx];
        end else s_valid = 1'b0;
        if (s_valid && s_ready) begin
          idx++;
          if (idx == 1) gap_left = gap;
        end
      end
    end
    start = 1'b0;
    if (!finished) check("load_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int exp_bubbles);
    check({tag, "_seq"}, seq, EXP_SEQ);
    check({tag, "_nshift"}, nsh, TOTAL);
    check({tag, "_bubbles"}, last_sh - first_sh + 1 - nsh, exp_bubbles);
    check({tag, "_cycles"}, lc, TOTAL + 1 + exp_bubbles);
    check({tag, "_chain"}, chain, EXP_CHAIN);
    check({tag, "_done_flags"}, {done, busy, s_ready, ccff_shift_en}, 4'b1000);
  endtask

  initial begin
    int acc16, nsh16, k16;
    logic [31:0] seq16;
    repeat (3) @(negedge prog_clk);
    check("reset_outputs", {busy, done, s_ready, ccff_head, ccff_shift_en}, 5'b0);
    check("reset_chain_ok", chain_ok, EXP_OK_RST);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);

    // Back-to-back words from IDLE.
    run_load(0, 0, 0, lc);
    check_result("nostall", 0);
    check("nostall_chain_ok", chain_ok, 1);

    // Start from DONE with a stall between words 1 and 2.
    run_load(GAP, 0, 0, lc);
    check("done_clears", first_done, 0);
    check_result("stall", 3);

    // start pulsed mid-load must be ignored.
    run_load(0, 8, 0, lc);
    check_result("start_mid", 0);

    // Stuck-at-0 flop in the chain, then a healthy reload.
    stuck = 22'h000400;
    run_load(0, 0, 0, lc);
    check("stuck_chain_ok", chain_ok, EXP_OK_STUCK);
    stuck = '0;
    run_load(0, 0, 0, lc);
    check("healthy_chain_ok", chain_ok, 1);

    // Reset after 10 completed shifts, then a fresh load.
    run_load(0, 0, 10, lc);
    check("after_reset_done", done, 0);
    run_load(0, 0, 0, lc);
    check_result("reload", 0);

    // CHAIN_LEN=16: only two words are taken; the third stays offered.
    acc16 = 0; nsh16 = 0; seq16 = '0;
    @(negedge prog_clk);
    start16 = 1'b1;
    for (k16 = 0; k16 < 100 && !done16; k16++) begin
      @(negedge prog_clk);
      start16 = 1'b0;
      if (shen16) begin seq16[nsh16] = head16; nsh16++; end
      if (!done16) begin
        s_valid16 = 1'b1;
        s_data16  = words16[(acc16 < 3) ? acc16 : 2];
        if (s_valid16 && s_ready16) acc16++;
      end
    end
    check("w16_done", done16, 1);
    repeat (5) begin
      @(negedge prog_clk);
      if (s_valid16 && s_ready16) acc16++;
    end
    check("w16_words", acc16, 2);
    check("w16_ready_after", s_ready16, 0);
    check("w16_nshift", nsh16, 16 + PRE_LEN);
    check("w16_seq", seq16, EXP_SEQ16);
    s_valid16 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
